seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_addsub_w.sv | 40 ++++
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential divider (state encoding, default width,
// divide-by-zero quotient). Signed operation is selected with the DIV_SIGNED_EN macro in seq_divider.
package div_pkg;

    localparam int DEF_WIDTH = 4;

    // Truncated to the operand width at the point of use.
    localparam logic [31:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/seq_divider_addsub_w.sv
// Parameterized ripple-carry adder/subtractor built from full adders.
// m=1 subtracts (b inverted, carry-in forced to 1); cout=1 then means "no borrow".
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_w #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         m,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] carry;

    assign carry[0] = m;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            full_adder u_fa (
                .a    (a[gi]),
                .b    (b[gi] ^ m),
                .cin  (carry[gi]),
                .s    (sum[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign cout = carry[N];
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock through a shared add/sub unit.
// Define DIV_SIGNED_EN for two's-complement operands (sign fix-up applied on entry to DONE).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH:0]   d_reg;
    logic [CW-1:0]    count_reg;

    logic             accept, dbz_start, last_iter;
    logic [WIDTH:0]   r_shift, t_diff, r_iter;
    logic [WIDTH-1:0] q_iter, dd_mag, dv_mag, q_fix, r_fix;
    logic             no_borrow;

    assign accept    = (state_reg != RUN) && start;
    assign dbz_start = accept && (divisor == '0);
    assign last_iter = (state_reg == RUN) && (count_reg == '0);

    // R_shifted: {R,Q} << 1 contributes Q's msb into R's lsb.
    assign r_shift = (r_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};

    addsub_w #(.N(WIDTH + 1)) u_addsub (
        .a    (r_shift),
        .b    (d_reg),
        .m    (1'b1),
        .sum  (t_diff),
        .cout (no_borrow)
    );

    assign q_iter = {q_reg[WIDTH-2:0], no_borrow};
    assign r_iter = no_borrow ? t_diff : r_shift;

`ifdef DIV_SIGNED_EN
    logic neg_q_reg, neg_r_reg;

    assign dd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dv_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    // Magnitude of most-negative fits unsigned, so -MIN/-1 wraps back to MIN naturally.
    assign q_fix  = neg_q_reg ? -q_iter : q_iter;
    assign r_fix  = neg_r_reg ? -r_iter[WIDTH-1:0] : r_iter[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (accept && !dbz_start) begin
            neg_q_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_reg <= dividend[WIDTH-1];
        end
    end
`else
    assign dd_mag = dividend;
    assign dv_mag = divisor;
    assign q_fix  = q_iter;
    assign r_fix  = r_iter[WIDTH-1:0];
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) state_next = dbz_start ? DONE : RUN;
                else        state_next = IDLE;
            end
            RUN: begin
                if (count_reg == '0) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept && !dbz_start) begin
                q_reg     <= dd_mag;
                r_reg     <= '0;
                d_reg     <= {1'b0, dv_mag};
                count_reg <= CW'(WIDTH - 1);
            end else if (state_reg == RUN) begin
                q_reg     <= q_iter;
                r_reg     <= r_iter;
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Result registers only move on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (dbz_start) begin
            quotient    <= DBZ_QUOTIENT[WIDTH-1:0];
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (last_iter) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor pops on done.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got q=%h r=%h expected no completion", quotient, remainder);
            end else begin
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.z));
                $display("txn q=%h r=%h dbz=%b (expected q=%h r=%h dbz=%b)",
                         quotient, remainder, div_by_zero, e.q, e.r, e.z);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle so a back-to-back start can follow.
    task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input exp_t e,
                          input bit inject);
        logic [W-1:0] held_q, held_r;
        int lat, nb, exp_lat, exp_busy;
        exp_lat  = (dv == '0) ? 1 : W + 1;
        exp_busy = (dv == '0) ? 0 : W;
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        sb.push_back(e);
        held_q = quotient;
        held_r = remainder;
        @(posedge clk);
        lat = 0;
        nb  = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (inject && lat == 2);
            if (inject && lat == 2) begin
                dividend = 4'h9;
                divisor  = 4'h2;
            end
            if (busy === 1'b1) begin
                nb++;
                check("hold_quotient", 32'(quotient), 32'(held_q));
                check("hold_remainder", 32'(remainder), 32'(held_r));
            end
        end while (done !== 1'b1 && lat < 20);
        check("done_latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(nb), 32'(exp_busy));
    endtask

    task automatic reset_mid_run(input logic [W-1:0] dd, input logic [W-1:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_dbz", 32'(div_by_zero), 32'd0);

`ifdef DIV_SIGNED_EN
        run_op(4'h9, 4'h2, '{q: 4'hD, r: 4'hF, z: 1'b0}, 1'b0);
        @(negedge clk);
        run_op(4'h8, 4'hF, '{q: 4'h8, r: 4'h0, z: 1'b0}, 1'b0);
        run_op(4'h7, 4'hE, '{q: 4'hD, r: 4'h1, z: 1'b0}, 1'b0);
        @(negedge clk);
        run_op(4'h7, 4'h0, '{q: 4'hF, r: 4'h7, z: 1'b1}, 1'b0);
        @(negedge clk);
        run_op(4'h6, 4'h4, '{q: 4'h1, r: 4'h2, z: 1'b0}, 1'b1);
        @(negedge clk);
        reset_mid_run(4'h5, 4'h3);
        run_op(4'h5, 4'h3, '{q: 4'h1, r: 4'h2, z: 1'b0}, 1'b0);
`else
        run_op(4'hD, 4'h3, '{q: 4'h4, r: 4'h1, z: 1'b0}, 1'b0);
        @(negedge clk);
        run_op(4'h7, 4'h0, '{q: 4'hF, r: 4'h7, z: 1'b1}, 1'b0);
        @(negedge clk);
        run_op(4'hF, 4'h1, '{q: 4'hF, r: 4'h0, z: 1'b0}, 1'b0);
        run_op(4'h2, 4'h9, '{q: 4'h0, r: 4'h2, z: 1'b0}, 1'b0);
        @(negedge clk);
        run_op(4'hC, 4'h5, '{q: 4'h2, r: 4'h2, z: 1'b0}, 1'b1);
        @(negedge clk);
        reset_mid_run(4'hB, 4'h3);
        run_op(4'hB, 4'h3, '{q: 4'h3, r: 4'h2, z: 1'b0}, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
